// File: rtl/alu_seq_muldiv.sv
// Registered integer ALU with an iterative radix-2 multiply/divide unit.
// Base operations return in one cycle. MUL*/DIV*/REM* operations take XLEN+2
// cycles through IDLE -> CALC -> FIN. Divide-by-zero and signed overflow are
// resolved directly in IDLE with single-cycle latency.
module alu_seq_muldiv #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            kill_i,
  input  logic [4:0]      op_i,
  input  logic [XLEN-1:0] rd1_i,
  input  logic [XLEN-1:0] src_b_i,
  output logic            valid_o,
  output logic [XLEN-1:0] alu_result_o,
  output logic            zero_o
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_e;

  // Which slice of the iterative datapath becomes the result in FIN.
  typedef enum logic [1:0] {SEL_LO, SEL_HI, SEL_QUO, SEL_REM} sel_e;

  typedef enum logic [4:0] {
    OP_ADD  = 5'd0,  OP_SUB    = 5'd1,  OP_SLL   = 5'd2,  OP_SLT   = 5'd3,
    OP_SLTU = 5'd4,  OP_XOR    = 5'd5,  OP_SRL   = 5'd6,  OP_SRA   = 5'd7,
    OP_OR   = 5'd8,  OP_AND    = 5'd9,  OP_MUL   = 5'd10, OP_MULH  = 5'd11,
    OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV  = 5'd14, OP_DIVU  = 5'd15,
    OP_REM  = 5'd16, OP_REMU   = 5'd17
  } op_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] p_q;       // mul: {acc, multiplier}; div: {remainder, quotient}
  logic [XLEN-1:0]   b_q;       // multiplicand / divisor magnitude
  logic              neg_q;     // negate the selected result in FIN
  sel_e              sel_q;
  logic [XLEN-1:0]   result_q;
  logic              zero_q;
  logic              valid_q;

  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   base_res;
  logic              md_req, a_sgn, b_sgn, a_neg, b_neg, is_div, div0, ovf;
  sel_e              sel_d;
  logic              neg_d;
  logic [XLEN-1:0]   a_mag, b_mag, spec_res;
  logic [XLEN:0]     mul_sum;
  logic [XLEN+1:0]   div_diff;
  logic [2*XLEN-1:0] step_d, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, fin_res;

  assign shamt = src_b_i[SHW-1:0];

  // Single-cycle base operations; unlisted codes fall through to ADD.
  always_comb begin
    // NOTE: assign a default before the case so every path drives the
    // signal; a missing branch would otherwise infer a latch.
    base_res = rd1_i + src_b_i;
    case (op_i)
      OP_SUB:  base_res = rd1_i - src_b_i;
      OP_SLL:  base_res = rd1_i << shamt;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(rd1_i) < $signed(src_b_i)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, rd1_i < src_b_i};
      OP_XOR:  base_res = rd1_i ^ src_b_i;
      OP_SRL:  base_res = rd1_i >> shamt;
      OP_SRA:  base_res = XLEN'($signed(rd1_i) >>> shamt);
      OP_OR:   base_res = rd1_i | src_b_i;
      OP_AND:  base_res = rd1_i & src_b_i;
      default: base_res = rd1_i + src_b_i;
    endcase
  end

  // Multiply/divide decode: operand signedness and result selection.
  always_comb begin
    md_req = 1'b1;
    a_sgn  = 1'b0;
    b_sgn  = 1'b0;
    sel_d  = SEL_LO;
    case (op_i)
      OP_MUL:    begin a_sgn = 1'b1; b_sgn = 1'b1; sel_d = SEL_LO;  end
      OP_MULH:   begin a_sgn = 1'b1; b_sgn = 1'b1; sel_d = SEL_HI;  end
      OP_MULHSU: begin a_sgn = 1'b1;               sel_d = SEL_HI;  end
      OP_MULHU:  begin                             sel_d = SEL_HI;  end
      OP_DIV:    begin a_sgn = 1'b1; b_sgn = 1'b1; sel_d = SEL_QUO; end
      OP_DIVU:   begin                             sel_d = SEL_QUO; end
      OP_REM:    begin a_sgn = 1'b1; b_sgn = 1'b1; sel_d = SEL_REM; end
      OP_REMU:   begin                             sel_d = SEL_REM; end
      default:   md_req = 1'b0;
    endcase
  end

  assign a_neg  = a_sgn & rd1_i[XLEN-1];
  assign b_neg  = b_sgn & src_b_i[XLEN-1];
  assign a_mag  = a_neg ? -rd1_i : rd1_i;
  assign b_mag  = b_neg ? -src_b_i : src_b_i;
  // Remainder takes the dividend's sign; products and quotients the XOR.
  assign neg_d  = (sel_d == SEL_REM) ? a_neg : (a_neg ^ b_neg);
  assign is_div = md_req & ((sel_d == SEL_QUO) | (sel_d == SEL_REM));
  assign div0   = is_div & (src_b_i == '0);
  assign ovf    = is_div & a_sgn & (rd1_i == MIN_NEG) & (src_b_i == {XLEN{1'b1}});
  assign spec_res = div0 ? ((sel_d == SEL_QUO) ? {XLEN{1'b1}} : rd1_i)
                         : ((sel_d == SEL_QUO) ? MIN_NEG : '0);

  // One iteration: right-shift shift-add multiply or restoring division.
  always_comb begin
    mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
    div_diff = {1'b0, p_q[2*XLEN-1:XLEN-1]} - {2'b00, b_q};
    if ((sel_q == SEL_LO) || (sel_q == SEL_HI))
      step_d = {mul_sum, p_q[XLEN-1:1]};
    else if (!div_diff[XLEN+1])
      step_d = {div_diff[XLEN-1:0], p_q[XLEN-2:0], 1'b1};
    else
      step_d = {p_q[2*XLEN-2:0], 1'b0};
  end

  // Sign correction and slice selection applied in FIN.
  always_comb begin
    prod_s = neg_q ? -p_q : p_q;
    quo_s  = neg_q ? -p_q[XLEN-1:0] : p_q[XLEN-1:0];
    rem_s  = neg_q ? -p_q[2*XLEN-1:XLEN] : p_q[2*XLEN-1:XLEN];
    case (sel_q)
      SEL_LO:  fin_res = prod_s[XLEN-1:0];
      SEL_HI:  fin_res = prod_s[2*XLEN-1:XLEN];
      SEL_QUO: fin_res = quo_s;
      default: fin_res = rem_s;
    endcase
  end

  // Control FSM with registered result, zero flag and valid pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      p_q      <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      sel_q    <= SEL_LO;
      result_q <= '0;
      zero_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (valid_i && !kill_i) begin
            if (!md_req) begin
              result_q <= base_res;
              zero_q   <= (base_res == '0);
              valid_q  <= 1'b1;
            end else if (div0 || ovf) begin
              result_q <= spec_res;
              zero_q   <= (spec_res == '0);
              valid_q  <= 1'b1;
            end else begin
              p_q     <= {{XLEN{1'b0}}, a_mag};
              b_q     <= b_mag;
              neg_q   <= neg_d;
              sel_q   <= sel_d;
              cnt_q   <= CW'(XLEN);
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (kill_i) begin
            state_q <= S_IDLE;
          end else begin
            p_q   <= step_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_q <= S_FIN;
          end
        end
        S_FIN: begin
          if (!kill_i) begin
            result_q <= fin_res;
            zero_q   <= (fin_res == '0);
            valid_q  <= 1'b1;
          end
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready_o      = (state_q == S_IDLE) & ~rst_i;
  assign valid_o      = valid_q;
  assign alu_result_o = result_q;
  assign zero_o       = zero_q;

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Scoreboard bench for alu_seq_muldiv: expected results come from a
// behavioural reference model (wide native arithmetic) or explicit constants.
module tb_alu_seq_muldiv;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        kill_i = 1'b0;
  logic [4:0]  op_i = '0;
  logic [31:0] rd1_i = '0;
  logic [31:0] src_b_i = '0;
  logic        valid_o;
  logic [31:0] alu_result_o;
  logic        zero_o;

  alu_seq_muldiv #(.XLEN(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .kill_i(kill_i), .op_i(op_i), .rd1_i(rd1_i), .src_b_i(src_b_i),
    .valid_o(valid_o), .alu_result_o(alu_result_o), .zero_o(zero_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference result using wide native arithmetic.
  function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] pr;
    logic signed [31:0] as_;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'd0, b});
    as_ = a;
    case (op)
      5'd1:  return a - b;
      5'd2:  return a << b[4:0];
      5'd3:  return {31'd0, $signed(a) < $signed(b)};
      5'd4:  return {31'd0, a < b};
      5'd5:  return a ^ b;
      5'd6:  return a >> b[4:0];
      5'd7:  return 32'(as_ >>> b[4:0]);
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: begin pr = 64'(sa * sb); return pr[31:0]; end
      5'd11: begin pr = 64'(sa * sb); return pr[63:32]; end
      5'd12: begin pr = 64'(sa * ub); return pr[63:32]; end
      5'd13: begin pr = {32'd0, a} * {32'd0, b}; return pr[63:32]; end
      5'd14: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        pr = 64'(sa / sb); return pr[31:0];
      end
      5'd15: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd16: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        pr = 64'(sa % sb); return pr[31:0];
      end
      5'd17: return (b == 0) ? a : a % b;
      default: return a + b;
    endcase
  endfunction

  function automatic int model_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 5'd10 || op > 5'd17) return 1;
    if (op >= 5'd14 && b == 0) return 1;
    if ((op == 5'd14 || op == 5'd16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issue one request, push its expectation, then wait for valid_o and compare.
  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    exp_t e, got;
    int   cyc;
    e.res = exp;
    e.lat = model_lat(op, a, b);
    sb_q.push_back(e);
    @(negedge clk_i);
    valid_i = 1'b1; op_i = op; rd1_i = a; src_b_i = b;
    @(posedge clk_i); #1;
    // Scramble inputs after accept: they must not influence the result.
    valid_i = 1'b0; op_i = 5'd1; rd1_i = ~a; src_b_i = a;
    cyc = 1;
    while (!valid_o && cyc < 100) begin
      if (cyc == 2 && e.lat > 1) check($sformatf("op%0d busy ready_o", op), ready_o, 0);
      @(posedge clk_i); #1;
      cyc++;
    end
    if (!valid_o) begin
      check($sformatf("op%0d timeout", op), 0, 1);
      void'(sb_q.pop_front());
    end else if (sb_q.size() == 0) begin
      check("scoreboard empty", 0, 1);
    end else begin
      got = sb_q.pop_front();
      check($sformatf("op%0d result", op), alu_result_o, got.res);
      check($sformatf("op%0d zero_o", op), zero_o, got.res == 0);
      check($sformatf("op%0d latency", op), cyc, got.lat);
      check($sformatf("op%0d ready_at_valid", op), ready_o, 1);
      @(posedge clk_i); #1;
      check($sformatf("op%0d valid_pulse", op), valid_o, 0);
    end
  endtask

  initial begin
    int          nval;
    logic [31:0] prev;
    logic [4:0]  rop;
    logic [31:0] ra, rb;

    // Reset state.
    repeat (2) @(posedge clk_i);
    #1;
    check("rst ready_o", ready_o, 0);
    check("rst valid_o", valid_o, 0);
    check("rst result", alu_result_o, 0);
    check("rst zero_o", zero_o, 0);
    @(negedge clk_i); rst_i = 1'b0;
    @(posedge clk_i); #1;
    check("ready after reset", ready_o, 1);

    // Directed vectors with hand-derived expectations.
    run_op(5'd0,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000);
    run_op(5'd1,  32'd5,         32'd5,         32'd0);
    run_op(5'd7,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000);
    run_op(5'd6,  32'h8000_0000, 32'h0000_0024, 32'h0800_0000);
    run_op(5'd3,  32'hFFFF_FFFF, 32'd1,         32'd1);
    run_op(5'd4,  32'hFFFF_FFFF, 32'd1,         32'd0);
    run_op(5'd31, 32'd2,         32'd3,         32'd5);
    run_op(5'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op(5'd13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op(5'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(5'd10, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
    run_op(5'd14, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    run_op(5'd16, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    run_op(5'd14, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run_op(5'd16, 32'd7,         32'hFFFF_FFFE, 32'd1);
    run_op(5'd15, 32'd100,       32'd7,         32'd14);
    run_op(5'd17, 32'd100,       32'd7,         32'd2);
    run_op(5'd14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run_op(5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    run_op(5'd15, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF);
    run_op(5'd17, 32'd9,         32'd0,         32'd9);

    // Randomised vectors against the reference model.
    for (int i = 0; i < 16; i++) begin
      rop = 5'($urandom_range(0, 19));
      if (rop == 5'd18) rop = 5'd25;
      if (rop == 5'd19) rop = 5'd31;
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_op(rop, ra, rb, model(rop, ra, rb));
    end

    // Kill during CALC: no result, ready next cycle, previous result held.
    run_op(5'd0, 32'd1, 32'd2, 32'd3);
    prev = alu_result_o;
    @(negedge clk_i);
    valid_i = 1'b1; op_i = 5'd14; rd1_i = 32'd1000; src_b_i = 32'd3;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (9) begin @(posedge clk_i); #1; end
    check("kill busy ready_o", ready_o, 0);
    kill_i = 1'b1;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    check("kill ready_o", ready_o, 1);
    check("kill result held", alu_result_o, prev);
    check("kill zero held", zero_o, 0);
    nval = 0;
    repeat (40) begin @(posedge clk_i); #1; if (valid_o) nval++; end
    check("kill no valid_o", nval, 0);

    // Kill in IDLE blocks acceptance.
    @(negedge clk_i);
    valid_i = 1'b1; kill_i = 1'b1; op_i = 5'd0; rd1_i = 32'd7; src_b_i = 32'd7;
    @(posedge clk_i); #1;
    valid_i = 1'b0; kill_i = 1'b0;
    check("idle kill no valid_o", valid_o, 0);
    check("idle kill result held", alu_result_o, prev);

    // Asynchronous reset mid-CALC.
    @(negedge clk_i);
    valid_i = 1'b1; op_i = 5'd10; rd1_i = 32'd3; src_b_i = 32'd4;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (4) begin @(posedge clk_i); #1; end
    rst_i = 1'b1;
    #1;
    check("async rst result", alu_result_o, 0);
    check("async rst zero_o", zero_o, 0);
    check("async rst valid_o", valid_o, 0);
    check("async rst ready_o", ready_o, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    nval = 0;
    repeat (40) begin @(posedge clk_i); #1; if (valid_o) nval++; end
    check("post rst no valid_o", nval, 0);
    run_op(5'd0, 32'd1, 32'd1, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_muldiv.md
Name: alu_seq_muldiv

Overview:
- Parametrised, registered successor to the single-cycle integer ALU, adding the RV32M/RV64M multiply/divide/remainder operations.
- Base ALU ops complete in 1 cycle; mul/div ops run on an iterative radix-2 datapath for XLEN+2 cycles.
- Sits in the execute stage behind a valid/ready handshake. The core stalls on ready_o and writes back on valid_o.

Parameters:
- XLEN, 32, operand/result width; must be even and >= 8.
- SHW, $clog2(XLEN), derived (localparam); shift-amount width.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-high
- valid_i  input  1  operation request
- ready_o  output  1  block idle, can accept a request
- kill_i  input  1  abort in-flight operation (pipeline flush)
- op_i  input  5  operation select
- rd1_i  input  XLEN  operand A
- src_b_i  input  XLEN  operand B
- valid_o  output  1  one-cycle pulse, result valid
- alu_result_o  output  XLEN  result; held until next valid_o
- zero_o  output  1  (alu_result_o == 0); registered with the result

Behaviour:
- Reset (rst_i high, asynchronous): state IDLE; valid_o=0; alu_result_o=0; zero_o=0; counter and internal registers cleared; ready_o=0 while rst_i is high.
- Accept: a request is accepted on a rising edge where valid_i & ready_o & ~kill_i. ready_o = (state==IDLE) & ~rst_i.
- op_i encoding:
  - 00000 ADD; 00001 SUB; 00010 SLL; 00011 SLT (signed); 00100 SLTU; 00101 XOR; 00110 SRL; 00111 SRA; 01000 OR; 01001 AND.
  - 01010 MUL; 01011 MULH; 01100 MULHSU; 01101 MULHU; 01110 DIV; 01111 DIVU; 10000 REM; 10001 REMU.
  - All other codes execute as ADD.
- Shifts: use only src_b_i[SHW-1:0]. SRA is arithmetic on signed rd1_i.
- Base ops: result and zero_o registered at the accepting edge; valid_o high the following cycle (latency 1). State remains IDLE.
- FSM for mul/div: IDLE -> CALC -> FIN -> IDLE.
  - IDLE: capture magnitudes and result sign (MULH signed*signed, MULHSU signed*unsigned, MULHU/DIVU/REMU unsigned); load counter = XLEN; go to CALC.
  - CALC: one shift-add (mul) or restoring shift-subtract (div) step per cycle; decrement counter; after XLEN steps go to FIN.
  - FIN: apply two's-complement sign correction; select low product (MUL), high product (MULH*), quotient or remainder; register result and zero_o; go to IDLE.
- Mul/div latency: valid_o high exactly XLEN+2 cycles after the accepting edge (34 for XLEN=32). No early-out for zero operands.
- Special cases, resolved in IDLE with latency 1 (same as base ops):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = rd1_i.
  - Signed overflow (rd1_i = most-negative, src_b_i = -1): DIV = most-negative; REM = 0.
- Remainder sign follows the dividend. Quotient truncates toward zero.
- valid_o: exactly one cycle per completed op. ready_o is high in that same cycle, so a back-to-back accept is permitted.
- kill_i:
  - In CALC or FIN: state -> IDLE at the next edge; no valid_o; alu_result_o and zero_o keep their previous values.
  - In IDLE: blocks acceptance that cycle; kill has priority over valid_i.
- Operands and op_i are sampled only at accept. Input changes during CALC have no effect.
- Async reset asserted mid-operation: abort immediately; no valid_o after release.

Test Plan:
- ADD 0x7FFFFFFF + 0x00000001 -> valid_o 1 cycle later, result 0x80000000, zero_o=0. SUB 5-5 -> 0, zero_o=1.
- SRA 0x80000000 by src_b_i = 0x00000024 (low 5 bits = 4) -> 0xF8000000. SRL same -> 0x08000000.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000. MULHU same -> 0xFFFFFFFE. MUL 0x00010000 x 0x00010000 -> 0x00000000. Each valid_o 34 cycles after accept; ready_o low during CALC/FIN.
- DIV -7 / 2 -> 0xFFFFFFFD; REM -7 % 2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU -> 2; latency 34 each.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same -> 0 with zero_o=1. DIVU x/0 -> 0xFFFFFFFF. REMU 9/0 -> 9. All four latency 1.
- Start DIV, assert kill_i at cycle 10 -> no valid_o, ready_o high next cycle, prior result held. Then start MUL 3x4 and assert rst_i mid-CALC -> all outputs 0, no valid_o. After release, ADD 1+1 -> 2.
